// File: rtl/pmem_pkg.sv
// Shared widths and enums for the cache-line pmem responder.
// Line is 256 bits; the low OFFSET_W address bits select a byte within the line and are ignored.
package pmem_pkg;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } pmem_op_t;
endpackage

// File: rtl/pmem_if.sv
// Cache-line pmem bus: requester holds read/write until the one-cycle resp pulse.
// master = cache side, slave = memory side.
interface pmem_if;
  import pmem_pkg::*;

  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              pmem_err;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp, pmem_err
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp, pmem_err
  );
endinterface

// File: rtl/pmem_line_array.sv
// Line storage: one combinational read port, one synchronous write port.
// Zero-latency read, write lands at the clock edge; no backpressure, contents never reset.
module pmem_line_array
  import pmem_pkg::*;
#(
  parameter int LINE_IDX_W = 8
) (
  input  logic                  clk,
  input  logic [LINE_IDX_W-1:0] rd_idx,
  output logic [LINE_W-1:0]     rd_dat,
  input  logic                  wr_en,
  input  logic [LINE_IDX_W-1:0] wr_idx,
  input  logic [LINE_W-1:0]     wr_dat
);
  logic [LINE_W-1:0] mem [0:(1<<LINE_IDX_W)-1];

  assign rd_dat = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_dat;
  end
endmodule

// File: rtl/pmem_responder.sv
// Pmem responder: one line read/write at a time, pmem_resp pulses LATENCY cycles after the request appears.
// Requester stalls by holding the request; optional PMEM_STATS_EN adds saturating rd/wr counters.
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int LINE_IDX_W = 8,
  parameter int LATENCY    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  pmem_if.slave       bus
`ifdef PMEM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);
  // BUSY lasts LATENCY-1 cycles, so the counter starts at LATENCY-2 and RESP follows count 0.
  localparam logic [7:0] CNT_LOAD = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  pmem_state_t           state;
  pmem_op_t              op_q;
  logic [7:0]            cnt;
  logic [LINE_IDX_W-1:0] idx_q;
  logic [LINE_W-1:0]     wdata_q;
  logic [LINE_W-1:0]     rdata_q;
  logic                  err_q;

  logic [LINE_IDX_W-1:0] addr_idx;
  logic [LINE_IDX_W-1:0] rd_idx;
  logic [LINE_W-1:0]     rd_line;
  logic                  wr_en;
  logic                  unused_addr;

  assign addr_idx    = bus.pmem_address[OFFSET_W +: LINE_IDX_W];
  assign unused_addr = ^{bus.pmem_address[OFFSET_W-1:0], bus.pmem_address[31:OFFSET_W+LINE_IDX_W]};

  // With LATENCY=1 the read happens on the accepting edge, before idx_q is loaded.
  assign rd_idx = (state == IDLE) ? addr_idx : idx_q;
  assign wr_en  = (state == RESP) && (op_q == OP_WR);

  pmem_line_array #(.LINE_IDX_W(LINE_IDX_W)) u_array (
    .clk    (clk),
    .rd_idx (rd_idx),
    .rd_dat (rd_line),
    .wr_en  (wr_en),
    .wr_idx (idx_q),
    .wr_dat (wdata_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= OP_RD;
      cnt     <= 8'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pmem_read ^ bus.pmem_write) begin
            op_q    <= bus.pmem_write ? OP_WR : OP_RD;
            idx_q   <= addr_idx;
            wdata_q <= bus.pmem_wdata;
            cnt     <= CNT_LOAD;
            if (LATENCY == 1) begin
              state <= RESP;
              if (bus.pmem_read) rdata_q <= rd_line;
            end else begin
              state <= BUSY;
            end
          end else if (bus.pmem_read && bus.pmem_write) begin
            err_q <= 1'b1;
          end
        end
        BUSY: begin
          if (!bus.pmem_read && !bus.pmem_write) begin
            state <= IDLE;
          end else if (cnt == 8'd0) begin
            state <= RESP;
            if (op_q == OP_RD) rdata_q <= rd_line;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_rdata = rdata_q;
  assign bus.pmem_resp  = (state == RESP);
  assign bus.pmem_err   = err_q;

`ifdef PMEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else if (state == RESP) begin
      if (op_q == OP_RD && rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      if (op_q == OP_WR && wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
    end
  end
`endif
endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Physical-memory responder: the far end of the 256-bit cache-line pmem interface driven by cache_hierarchy.
- Accepts one line read or line write at a time.
- Serves it from an internal line array after a programmable latency.
- Pulses pmem_resp for exactly one cycle per transaction.
- Used as the synthesizable/simulation memory behind the CPU + cache top level.

Parameters:
- LINE_IDX_W, 8, log2 of number of 32-byte lines stored (default 256 lines = 8 KiB)
- LATENCY, 10, cycles from request first visible to pmem_resp high; legal range 1..255

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- pmem_read  in  1  line read request, held high until pmem_resp
- pmem_write  in  1  line write request, held high until pmem_resp
- pmem_address  in  32  byte address; bits [4:0] ignored
- pmem_wdata  in  256  write line data
- pmem_rdata  out  256  read line data, valid in pmem_resp cycle of a read
- pmem_resp  out  1  one-cycle completion pulse
- pmem_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, counter 0, pmem_resp 0, pmem_rdata 0, pmem_err 0. Array contents are not reset.
- Line index = pmem_address[5 +: LINE_IDX_W]. Higher bits alias (wrap-around); no fault.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Samples requests each edge.
  - Exactly one of read/write high in cycle t: latch op, index, wdata; load counter; move to BUSY (or straight to RESP when LATENCY=1).
  - Result: pmem_resp high in cycle t+LATENCY.
- BUSY:
  - Counter decrements each cycle; transition to RESP timed so resp lands at t+LATENCY.
  - If the request deasserts during BUSY (both read and write low): abort, return to IDLE, no array write, no resp.
- RESP: pmem_resp=1 for one cycle; always returns to IDLE.
  - Read: pmem_rdata = array[index] in this cycle. pmem_rdata is registered and holds its value afterwards until the next read completes.
  - Write: array[index] <= latched wdata at the end of this cycle.
- Back-to-back: a new request visible in the first IDLE cycle after RESP is accepted immediately, so the minimum gap is one idle cycle. A read of a just-written line returns the new data.
- pmem_read and pmem_write both high in IDLE:
  - pmem_err set (sticky until reset).
  - Request ignored; FSM stays IDLE.
  - pmem_resp never asserted for it.
- Request data or address changing during BUSY is ignored; latched values are used.
- pmem_resp is never high outside RESP and never high in two consecutive cycles.

Optional Feature:
- Macro PMEM_STATS_EN.
- When defined:
  - Adds outputs rd_count[31:0] and wr_count[31:0].
  - Each increments on a completed read/write RESP cycle and saturates at 32'hFFFFFFFF.
  - Reset value 0; aborted requests are not counted.
- When undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Package pmem_pkg holds:
  - LINE_W=256, OFFSET_W=5
  - state enum pmem_state_t {IDLE, BUSY, RESP}
  - op enum pmem_op_t {OP_RD, OP_WR}
- Sub-module pmem_line_array (1 read port, 1 write port, combinational read, synchronous write, parameter LINE_IDX_W) contains the storage.
- pmem_responder holds the FSM, latency counter, latches, error and stats logic.

Test Plan:
- Write 0xA5..A5 line to 0x0000_0040, then read 0x0000_0040 -> each pmem_resp exactly at request cycle+10, read pmem_rdata=0xA5..A5.
- LATENCY=1 build: read request in cycle t -> pmem_resp in t+1, back-to-back reads accepted with one idle cycle between.
- Write to 0x0000_2020 (index 1 with LINE_IDX_W=8 wraps), read 0x0000_0020 -> same data returned (aliasing).
- Raise pmem_read, drop it after 4 cycles -> no pmem_resp, FSM IDLE; subsequent write completes normally at +10.
- Assert pmem_read and pmem_write together -> pmem_err=1 next cycle and stays 1, no pmem_resp; pull rst_n low mid-BUSY of a later write -> pmem_resp, pmem_rdata, pmem_err immediately 0, target line unchanged.
- With PMEM_STATS_EN: 3 reads, 2 writes, 1 aborted read -> rd_count=3, wr_count=2.
